m_stage: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline, directly upstream of the writeback stage.
- Holds the EX/MEM pipeline register and a word-organised data memory.
- Executes stores with byte/halfword enables; produces sign- or zero-extended load data.
- Passes instr/pc/pc4/ALU result onward; the writeback stage latches them together with the load data.

---
 rtl/m_stage.sv | 171 +++++++++++++++++
 tb/tb_m_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage.sv
// m_stage -- memory stage of the 5-stage MIPS pipeline.
//
// Holds the EX/MEM pipeline register (IR_M, PC_M, PC4_M, AO_M, RT_M) and a
// word-organised data memory. Stores (sw/sh/sb) commit on the clock edge
// that follows the store's arrival in this stage. Load data (lw/lh/lhu/lb/
// lbu) is combinational from the addressed word, and the writeback stage
// registers it. The memory index is AO_M[DM_AW+1:2], so addresses wrap modulo
// DM_WORDS*4.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high; clears pipeline registers and memory
//   instr      instruction leaving EX
//   pc, pc4    PC and PC+4 of that instruction
//   ao         ALU result; byte address for loads/stores
//   rt_data    forwarded rt value; store data
//   instr_out  IR_M
//   pc_out     PC_M
//   pc4_out    PC4_M
//   ao_out     AO_M
//   dr         extended load data (raw word for non-loads)
//   misalign   misaligned-access flag
//
// Optional feature: define MISALIGN_CHK_EN to flag misaligned lw/sw/lh/lhu/sh.
// When it is defined, misaligned stores are suppressed and misaligned loads
// return 0. Without it, misalign is tied 0 and the low address bits that do
// not fit the access size are ignored.
module m_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [31:0] ao,
  input  logic [31:0] rt_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] ao_out,
  output logic [31:0] dr,
  output logic        misalign
);

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic [31:0] ir_q, pc_q, pc4_q, ao_q, rt_q;
  logic [31:0] mem_q [DM_WORDS];

  logic [5:0]       op;
  logic [DM_AW-1:0] idx;
  logic [1:0]       bo;
  logic [31:0]      word;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;
  logic             is_load;
  logic             misal;
  logic             st_en;
  logic [31:0]      wdata_d;
  logic [31:0]      dr_d;

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // ---- MEM stage: decode, load extraction, store merge ----
  always_comb begin
    op       = ir_q[31:26];
    idx      = ao_q[DM_AW+1:2];
    bo       = ao_q[1:0];
    word     = mem_q[idx];
    half_sel = ao_q[1] ? word[31:16] : word[15:0];
    case (bo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    is_load = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
              (op == OP_LB) || (op == OP_LBU);

`ifdef MISALIGN_CHK_EN
    misal = (((op == OP_LW) || (op == OP_SW)) && (bo != 2'd0)) ||
            (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && ao_q[0]);
`else
    misal = 1'b0;
`endif

    case (op)
      OP_LW:   dr_d = word;
      OP_LH:   dr_d = ext16(half_sel, 1'b1);
      OP_LHU:  dr_d = ext16(half_sel, 1'b0);
      OP_LB:   dr_d = ext8(byte_sel, 1'b1);
      OP_LBU:  dr_d = ext8(byte_sel, 1'b0);
      default: dr_d = word;
    endcase
    if (misal && is_load) dr_d = '0;

    // Merged word: untouched bytes come from the current memory contents.
    wdata_d = word;
    st_en   = 1'b0;
    case (op)
      OP_SW: begin
        wdata_d = rt_q;
        st_en   = 1'b1;
      end
      OP_SH: begin
        if (ao_q[1]) wdata_d[31:16] = rt_q[15:0];
        else         wdata_d[15:0]  = rt_q[15:0];
        st_en = 1'b1;
      end
      OP_SB: begin
        case (bo)
          2'd0:    wdata_d[7:0]   = rt_q[7:0];
          2'd1:    wdata_d[15:8]  = rt_q[7:0];
          2'd2:    wdata_d[23:16] = rt_q[7:0];
          default: wdata_d[31:24] = rt_q[7:0];
        endcase
        st_en = 1'b1;
      end
      default: ;
    endcase
    if (misal) st_en = 1'b0;
  end

  // ---- EX/MEM register and memory commit ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= '0;
      pc_q  <= '0;
      pc4_q <= '0;
      ao_q  <= '0;
      rt_q  <= '0;
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      ir_q  <= instr;
      pc_q  <= pc;
      pc4_q <= pc4;
      ao_q  <= ao;
      rt_q  <= rt_data;
      if (st_en) begin
        mem_q[idx] <= wdata_d;
`ifndef SYNTHESIS
        $display("@%h: *%h <= %h", pc_q, {ao_q[31:2], 2'b00}, wdata_d);
`endif
      end
    end
  end

  assign instr_out = ir_q;
  assign pc_out    = pc_q;
  assign pc4_out   = pc4_q;
  assign ao_out    = ao_q;
  assign dr        = dr_d;
  assign misalign  = misal;

endmodule

// File: tb/tb_m_stage.sv
module tb_m_stage;

  localparam int DM_WORDS = 1024;

  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] NOP = 6'b000000;

`ifdef MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, pc4, ao, rt_data;
  logic [31:0] instr_out, pc_out, pc4_out, ao_out, dr;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  m_stage #(.DM_WORDS(DM_WORDS), .DM_AW(10)) dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc), .pc4(pc4), .ao(ao),
    .rt_data(rt_data), .instr_out(instr_out), .pc_out(pc_out),
    .pc4_out(pc4_out), .ao_out(ao_out), .dr(dr), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Behavioural model: byte-addressed view of memory plus the instruction
  // currently occupying the stage.
  logic [31:0] m_mem [DM_WORDS];
  logic [31:0] m_ir, m_pc, m_pc4, m_ao, m_rt;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DM_WORDS);
  endfunction

  function automatic bit exp_mis();
    int b;
    logic [5:0] op;
    b  = int'(m_ao % 4);
    op = m_ir[31:26];
    if (!CHK) return 1'b0;
    if ((op == LW || op == SW) && b != 0) return 1'b1;
    if ((op == LH || op == LHU || op == SH) && (b % 2) == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_dr();
    logic [31:0] w, r;
    logic [5:0]  op;
    int b;
    w  = m_mem[widx(m_ao)];
    b  = int'(m_ao % 4);
    op = m_ir[31:26];
    r  = w;
    if (op == LH || op == LHU) begin
      r = (w >> (16 * (b / 2))) & 32'h0000FFFF;
      if (op == LH && r >= 32'h8000) r = r | 32'hFFFF0000;
    end else if (op == LB || op == LBU) begin
      r = (w >> (8 * b)) & 32'h000000FF;
      if (op == LB && r >= 32'h80) r = r | 32'hFFFFFF00;
    end
    if (exp_mis() && (op == LW || op == LH || op == LHU || op == LB || op == LBU))
      r = 32'h0;
    return r;
  endfunction

  task automatic model_store();
    int w, b;
    logic [5:0] op;
    w  = widx(m_ao);
    b  = int'(m_ao % 4);
    op = m_ir[31:26];
    if (exp_mis()) return;
    if (op == SW) begin
      for (int k = 0; k < 4; k++) m_mem[w][8*k +: 8] = m_rt[8*k +: 8];
    end else if (op == SH) begin
      for (int k = 0; k < 2; k++) m_mem[w][8*((b/2)*2 + k) +: 8] = m_rt[8*k +: 8];
    end else if (op == SB) begin
      m_mem[w][8*b +: 8] = m_rt[7:0];
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) m_mem[i] = 32'h0;
      m_ir = 0; m_pc = 0; m_pc4 = 0; m_ao = 0; m_rt = 0;
    end else begin
      model_store();
      m_ir = instr; m_pc = pc; m_pc4 = pc4; m_ao = ao; m_rt = rt_data;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("instr_out", instr_out, m_ir);
      check32("pc_out", pc_out, m_pc);
      check32("pc4_out", pc4_out, m_pc4);
      check32("ao_out", ao_out, m_ao);
      check32("dr", dr, exp_dr());
      check32("misalign", {31'b0, misalign}, {31'b0, exp_mis()});
    end
  end

  task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    instr   = {op, 26'h0A48000 ^ {16'h0, a[9:0]}};
    pc      = pc + 32'd4;
    pc4     = pc + 32'd4;
    ao      = a;
    rt_data = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; instr = 0; pc = 32'h0040_0000; pc4 = 0; ao = 0; rt_data = 0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    check32("rst_instr_out", instr_out, 32'h0);
    check32("rst_pc_out", pc_out, 32'h0);
    check32("rst_pc4_out", pc4_out, 32'h0);
    check32("rst_ao_out", ao_out, 32'h0);
    check32("rst_misalign", {31'b0, misalign}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(LW, 32'(i * 4), 32'h0);
      check32("lw_after_reset", dr, 32'h0);
    end

    step(SW, 32'h10, 32'h8899AABB);
    step(LW, 32'h10, 32'h0);
    check32("sw_lw_dr", dr, 32'h8899AABB);
    check32("model_sw_lw", exp_dr(), 32'h8899AABB);

    step(SB, 32'h12, 32'h000000CC);
    step(LB, 32'h12, 32'h0);
    check32("lb_dr", dr, 32'hFFFFFFCC);
    check32("model_lb", exp_dr(), 32'hFFFFFFCC);
    step(LBU, 32'h12, 32'h0);
    check32("lbu_dr", dr, 32'h000000CC);
    step(LW, 32'h10, 32'h0);
    check32("sb_word", dr, 32'h88CCAABB);

    step(SH, 32'h10, 32'h00001234);
    step(LH, 32'h12, 32'h0);
    check32("lh_dr", dr, 32'hFFFF88CC);
    check32("model_lh", exp_dr(), 32'hFFFF88CC);
    step(LHU, 32'h12, 32'h0);
    check32("lhu_dr", dr, 32'h000088CC);
    step(LW, 32'h10, 32'h0);
    check32("sh_word", dr, 32'h88CC1234);

    step(SH, 32'h12, 32'hFFFFBEEF);
    step(LH, 32'h10, 32'h0);
    check32("lh_low_pos", dr, 32'h00001234);
    step(LB, 32'h13, 32'h0);
    check32("lb_top", dr, 32'hFFFFFFBE);
    step(LBU, 32'h11, 32'h0);
    check32("lbu_b1", dr, 32'h00000012);
    step(SB, 32'h10, 32'h00000080);
    step(LB, 32'h10, 32'h0);
    check32("lb_b0_neg", dr, 32'hFFFFFF80);
    step(NOP, 32'h10, 32'h0);
    check32("nonload_raw", dr, 32'hBEEF1280);

    step(SW, 32'hFFFFF004, 32'hCAFEF00D);
    step(LW, 32'h4, 32'h0);
    check32("addr_wrap", dr, 32'hCAFEF00D);

    // Reset on the edge where the sw to 0x20 would commit.
    step(SW, 32'h20, 32'hDEADBEEF);
    reset = 1'b1; instr = 0; ao = 0; rt_data = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    check32("rst_collide_ir", instr_out, 32'h0);
    step(LW, 32'h20, 32'h0);
    check32("rst_collide_mem8", dr, 32'h0);
    step(LW, 32'h10, 32'h0);
    check32("rst_clears_mem4", dr, 32'h0);

    step(SW, 32'h21, 32'h11223344);
    check32("sw_mis_flag", {31'b0, misalign}, CHK ? 32'h1 : 32'h0);
    step(LW, 32'h20, 32'h0);
`ifdef MISALIGN_CHK_EN
    check32("sw_mis_mem8", dr, 32'h0);
`else
    check32("sw_mis_mem8", dr, 32'h11223344);
`endif
    step(LH, 32'h21, 32'h0);
`ifdef MISALIGN_CHK_EN
    check32("lh_mis_flag", {31'b0, misalign}, 32'h1);
    check32("lh_mis_dr", dr, 32'h0);
`else
    check32("lh_mis_flag", {31'b0, misalign}, 32'h0);
    check32("lh_mis_dr", dr, 32'h00003344);
`endif
    step(LBU, 32'h21, 32'h0);
    check32("lbu_odd_flag", {31'b0, misalign}, 32'h0);
`ifdef MISALIGN_CHK_EN
    check32("lbu_odd_dr", dr, 32'h0);
`else
    check32("lbu_odd_dr", dr, 32'h00000033);
`endif

    step(NOP, 32'h0, 32'h0);
    step(NOP, 32'h0, 32'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
